// File: rtl/register_scoreboard_file_pkg.sv
// Shared CPU widths and types for the register file, decode and writeback.
package register_scoreboard_file_pkg;

  localparam int DATA_WIDTH              = 32;
  localparam int NUM_REGISTERS           = 32;
  localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);
  localparam int MAX_PENDING             = 3;
  localparam int PENDING_WIDTH           = $clog2(MAX_PENDING + 1);

  typedef logic [REGISTER_INDEXING_WIDTH-1:0] reg_index_t;
  typedef logic [DATA_WIDTH-1:0]              reg_data_t;
  typedef logic [PENDING_WIDTH-1:0]           pending_count_t;

endpackage

// File: rtl/register_scoreboard_file_if.sv
// Decode read/reserve ports, writeback port and flush for the scoreboarded register file.
interface register_scoreboard_file_if;
  import register_scoreboard_file_pkg::*;

  reg_index_t read_1_index;
  reg_data_t  read_1_data;
  logic       read_1_contended;
  reg_index_t read_2_index;
  reg_data_t  read_2_data;
  logic       read_2_contended;
  // reserve is a valid/ready pair: a reservation takes effect on a clock edge
  // where reserve_valid and reserve_ready are both high; valid with ready low is an error.
  logic       reserve_valid;
  reg_index_t reserve_index;
  logic       reserve_ready;
  logic       writeback_valid;
  reg_index_t writeback_index;
  reg_data_t  writeback_data;
  logic       flush;
  logic       pending_any;
  logic       protocol_error;

  modport master (
    output read_1_index, read_2_index, reserve_valid, reserve_index,
           writeback_valid, writeback_index, writeback_data, flush,
    input  read_1_data, read_1_contended, read_2_data, read_2_contended,
           reserve_ready, pending_any, protocol_error
  );

  modport slave (
    input  read_1_index, read_2_index, reserve_valid, reserve_index,
           writeback_valid, writeback_index, writeback_data, flush,
    output read_1_data, read_1_contended, read_2_data, read_2_contended,
           reserve_ready, pending_any, protocol_error
  );

endinterface

// File: rtl/register_scoreboard_file_read_port.sv
// One decode read port: writeback bypass plus pending-write contention check.
module scoreboard_read_port
  import register_scoreboard_file_pkg::*;
(
  input  reg_index_t     read_index,
  input  reg_data_t      stored_data,
  input  pending_count_t count,
  input  logic           writeback_valid,
  input  reg_index_t     writeback_index,
  input  reg_data_t      writeback_data,
  output reg_data_t      data,
  output logic           contended
);

  logic hit;

  assign hit = writeback_valid && (writeback_index == read_index);

  // A same-cycle writeback satisfies one of the pending writes.
  always_comb begin
    data      = '0;
    contended = 1'b0;
    if (read_index != '0) begin
      data      = hit ? writeback_data : stored_data;
      contended = count > pending_count_t'(hit);
    end
  end

endmodule

// File: rtl/register_scoreboard_file.sv
// Architectural register file with a per-register pending-write counter scoreboard.
module register_scoreboard_file
  import register_scoreboard_file_pkg::*;
(
  input logic                        clk,
  input logic                        rst,
  register_scoreboard_file_if.slave  sb
);

  reg_data_t      data_q  [NUM_REGISTERS];
  pending_count_t count_q [NUM_REGISTERS];
  pending_count_t count_d [NUM_REGISTERS];
  logic           error_q;
  logic           reserve_error;
  logic           writeback_error;

  assign sb.reserve_ready = (sb.reserve_index == '0) ||
                            (count_q[sb.reserve_index] < pending_count_t'(MAX_PENDING));

  assign reserve_error   = sb.reserve_valid && !sb.reserve_ready;
  assign writeback_error = sb.writeback_valid && (sb.writeback_index != '0) &&
                           (count_q[sb.writeback_index] == '0);

  // Rejected reserves and unowed writebacks leave the counter untouched, so it never wraps.
  always_comb begin
    logic res_hit;
    logic wb_hit;
    res_hit    = 1'b0;
    wb_hit     = 1'b0;
    count_d[0] = '0;
    for (int i = 1; i < NUM_REGISTERS; i++) begin
      res_hit    = sb.reserve_valid && sb.reserve_ready &&
                   (sb.reserve_index == reg_index_t'(i));
      wb_hit     = sb.writeback_valid && (sb.writeback_index == reg_index_t'(i)) &&
                   (count_q[i] != '0);
      count_d[i] = count_q[i] + pending_count_t'(res_hit) - pending_count_t'(wb_hit);
      if (sb.flush) count_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGISTERS; i++) begin
        data_q[i]  <= '0;
        count_q[i] <= '0;
      end
      error_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGISTERS; i++) count_q[i] <= count_d[i];
      // Data is written even when the writeback is flagged as unowed or squashed.
      if (sb.writeback_valid && (sb.writeback_index != '0))
        data_q[sb.writeback_index] <= sb.writeback_data;
      if (reserve_error || writeback_error) error_q <= 1'b1;
    end
  end

  always_comb begin
    sb.pending_any = 1'b0;
    for (int i = 0; i < NUM_REGISTERS; i++)
      if (count_q[i] != '0) sb.pending_any = 1'b1;
  end

  assign sb.protocol_error = error_q;

  scoreboard_read_port u_read_1 (
    .read_index      (sb.read_1_index),
    .stored_data     (data_q[sb.read_1_index]),
    .count           (count_q[sb.read_1_index]),
    .writeback_valid (sb.writeback_valid),
    .writeback_index (sb.writeback_index),
    .writeback_data  (sb.writeback_data),
    .data            (sb.read_1_data),
    .contended       (sb.read_1_contended)
  );

  scoreboard_read_port u_read_2 (
    .read_index      (sb.read_2_index),
    .stored_data     (data_q[sb.read_2_index]),
    .count           (count_q[sb.read_2_index]),
    .writeback_valid (sb.writeback_valid),
    .writeback_index (sb.writeback_index),
    .writeback_data  (sb.writeback_data),
    .data            (sb.read_2_data),
    .contended       (sb.read_2_contended)
  );

endmodule
